// File: rtl/mem_store_rmw_pkg.sv
// Shared definitions for the store read-modify-write block: access-size
// codes, FSM state encoding and the alignment/legality helper.
package mem_store_rmw_pkg;

    // Access size encoding shared with the load extractor; 2'b11 is undefined.
    localparam int MEM_ACCESS_SIZE_WIDTH = 2;
    localparam logic [MEM_ACCESS_SIZE_WIDTH-1:0] MEM_ACCESS_SIZE_BYTE = 2'd0;
    localparam logic [MEM_ACCESS_SIZE_WIDTH-1:0] MEM_ACCESS_SIZE_HALF = 2'd1;
    localparam logic [MEM_ACCESS_SIZE_WIDTH-1:0] MEM_ACCESS_SIZE_WORD = 2'd2;

    // Store FSM state encoding.
    localparam int STORE_ST_WIDTH = 3;
    typedef enum logic [STORE_ST_WIDTH-1:0] {
        STORE_ST_IDLE = 3'd0,
        STORE_ST_RD   = 3'd1,
        STORE_ST_WR   = 3'd2,
        STORE_ST_DONE = 3'd3,
        STORE_ST_ERR  = 3'd4
    } store_state_t;

    // A store is rejected when its size code is undefined or the address is
    // not naturally aligned for that size. Bytes are always aligned.
    function automatic logic store_illegal(
        input logic [MEM_ACCESS_SIZE_WIDTH-1:0] size,
        input logic [1:0]                       addr_lo
    );
        logic bad;
        case (size)
            MEM_ACCESS_SIZE_BYTE: bad = 1'b0;
            MEM_ACCESS_SIZE_HALF: bad = addr_lo[0];
            MEM_ACCESS_SIZE_WORD: bad = (addr_lo != 2'b00);
            default:              bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: inserts the right-aligned store data into the
// word read back from memory at the lane selected by the low address bits.
module store_lane_merge
    import mem_store_rmw_pkg::*;
(
    input  logic [31:0]                      rd,
    input  logic [31:0]                      d,
    input  logic [MEM_ACCESS_SIZE_WIDTH-1:0] size,
    input  logic [1:0]                       addr_lo,
    output logic [31:0]                      merged
);

    // Start from the read word and overwrite only the lane being stored;
    // a full word store ignores the read word entirely.
    always_comb begin
        merged = rd;
        case (size)
            MEM_ACCESS_SIZE_BYTE: begin
                case (addr_lo)
                    2'd0:    merged[7:0]   = d[7:0];
                    2'd1:    merged[15:8]  = d[7:0];
                    2'd2:    merged[23:16] = d[7:0];
                    default: merged[31:24] = d[7:0];
                endcase
            end
            MEM_ACCESS_SIZE_HALF: begin
                if (addr_lo[1]) begin
                    merged[31:16] = d[15:0];
                end else begin
                    merged[15:0] = d[15:0];
                end
            end
            MEM_ACCESS_SIZE_WORD: begin
                merged = d;
            end
            default: begin
                merged = rd;
            end
        endcase
    end

endmodule

// File: rtl/mem_store_rmw.sv
// Store unit for a word-only data memory. Word stores are written directly;
// byte and half stores fetch the aligned word, merge the new lane and write
// it back. Busy stalls the pipeline until the store commits or is rejected.
module mem_store_rmw
    import mem_store_rmw_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             st_req_i,
    input  logic [AW-1:0]                    st_addr_i,
    input  logic [DW-1:0]                    st_data_i,
    input  logic [MEM_ACCESS_SIZE_WIDTH-1:0] st_size_i,
    output logic                             st_busy_o,
    output logic                             st_done_o,
    output logic                             st_err_o,
    output logic                             mem_req_o,
    output logic                             mem_we_o,
    output logic [AW-1:0]                    mem_addr_o,
    output logic [DW-1:0]                    mem_wdata_o,
    input  logic [DW-1:0]                    mem_rdata_i,
    input  logic                             mem_ack_i
);

    store_state_t                     state;
    logic [AW-1:0]                    addr_q;
    logic [DW-1:0]                    data_q;
    logic [MEM_ACCESS_SIZE_WIDTH-1:0] size_q;
    logic [DW-1:0]                    rdata_q;
    logic [DW-1:0]                    merged_word;

    store_lane_merge u_merge (
        .rd      (rdata_q),
        .d       (data_q),
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .merged  (merged_word)
    );

    // Store sequencing: accept and classify in IDLE, hold each memory
    // request until acknowledged, then pulse done or error for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= STORE_ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                STORE_ST_IDLE: begin
                    if (st_req_i) begin
                        addr_q <= st_addr_i;
                        data_q <= st_data_i;
                        size_q <= st_size_i;
                        if (store_illegal(st_size_i, st_addr_i[1:0])) begin
                            state <= STORE_ST_ERR;
                        end else if (st_size_i == MEM_ACCESS_SIZE_WORD) begin
                            state <= STORE_ST_WR;
                        end else begin
                            state <= STORE_ST_RD;
                        end
                    end
                end
                STORE_ST_RD: begin
                    if (mem_ack_i) begin
                        rdata_q <= mem_rdata_i;
                        state   <= STORE_ST_WR;
                    end
                end
                STORE_ST_WR: begin
                    if (mem_ack_i) begin
                        state <= STORE_ST_DONE;
                    end
                end
                STORE_ST_DONE: begin
                    state <= STORE_ST_IDLE;
                end
                STORE_ST_ERR: begin
                    state <= STORE_ST_IDLE;
                end
                default: begin
                    state <= STORE_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from the state register only, so they hold steady while
    // waiting for ack and all drop as soon as reset forces the state to IDLE.
    always_comb begin
        st_busy_o   = (state != STORE_ST_IDLE);
        st_done_o   = (state == STORE_ST_DONE);
        st_err_o    = (state == STORE_ST_ERR);
        mem_req_o   = (state == STORE_ST_RD) || (state == STORE_ST_WR);
        mem_we_o    = (state == STORE_ST_WR);
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            mem_addr_o = {addr_q[AW-1:2], 2'b00};
        end
        if (state == STORE_ST_WR) begin
            mem_wdata_o = merged_word;
        end
    end

endmodule

// File: tb/tb_mem_store_rmw.sv
// Bench for mem_store_rmw: a behavioural memory with random wait states
// answers requests, a byte-addressed reference model predicts every write,
// and a monitor compares the DUT's memory traffic against the predictions.
module tb_mem_store_rmw;
    import mem_store_rmw_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_req_i = 1'b0;
    logic [31:0] st_addr_i = '0;
    logic [31:0] st_data_i = '0;
    logic [1:0]  st_size_i = '0;
    logic        st_busy_o, st_done_o, st_err_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;

    mem_store_rmw #(.AW(32), .DW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_req_i    (st_req_i),
        .st_addr_i   (st_addr_i),
        .st_data_i   (st_data_i),
        .st_size_i   (st_size_i),
        .st_busy_o   (st_busy_o),
        .st_done_o   (st_done_o),
        .st_err_o    (st_err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] dev_mem [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;
    int err_count = 0;
    int write_count = 0;
    int last_event_cyc = 0;

    int  wait_q[$];
    int  wait_left = -1;
    bit  zero_wait = 1'b1;
    bit  ack_hold = 1'b0;
    bit  spurious_ack = 1'b0;

    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    logic [64:0] prev_req_bus = '0;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Contents of never-written memory: a fixed scramble of the word address.
    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] dev_read(input logic [31:0] wa);
        if (dev_mem.exists(wa)) return dev_mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (ref_mem.exists(a)) return ref_mem[a];
        w = init_word({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic preload(input logic [31:0] wa, input logic [31:0] w);
        dev_mem[wa] = w;
        for (int i = 0; i < 4; i++) ref_mem[wa + i] = w[8*i +: 8];
    endtask

    // Reference model: a store of N bytes is legal only if its address is a
    // multiple of N; it updates N consecutive little-endian bytes and the
    // memory must then see the whole containing word written.
    function automatic bit model_push(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        int          nbytes;
        logic [31:0] base;
        exp_t        e;
        case (size)
            2'd0:    nbytes = 1;
            2'd1:    nbytes = 2;
            2'd2:    nbytes = 4;
            default: nbytes = 0;
        endcase
        if (nbytes == 0 || (addr % nbytes) != 0) begin
            e.is_err = 1'b1;
            e.addr   = '0;
            e.data   = '0;
            exp_q.push_back(e);
            return 1'b0;
        end
        base = addr & 32'hFFFF_FFFC;
        if (nbytes < 4) rd_q.push_back(base);
        for (int i = 0; i < nbytes; i++) ref_mem[addr + i] = data[8*i +: 8];
        e.is_err = 1'b0;
        e.addr   = base;
        e.data   = {ref_byte(base + 3), ref_byte(base + 2), ref_byte(base + 1), ref_byte(base)};
        exp_q.push_back(e);
        return 1'b1;
    endfunction

    // Behavioural memory: each request is acknowledged after a wait taken
    // from wait_q, zero, or a random 0..3 cycles; writes land on the ack.
    always @(negedge clk) begin
        if (rst) begin
            mem_ack_i = 1'b0;
            wait_left = -1;
        end else if (!mem_req_o) begin
            mem_ack_i   = spurious_ack;
            mem_rdata_i = $urandom;
            wait_left   = -1;
        end else begin
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                wait_left = -1;
            end
            if (wait_left < 0) begin
                if (wait_q.size() > 0) wait_left = wait_q.pop_front();
                else if (zero_wait) wait_left = 0;
                else wait_left = int'($urandom_range(0, 3));
            end
            if (ack_hold || wait_left != 0) begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = $urandom;
                if (!ack_hold) wait_left--;
            end else begin
                mem_ack_i = 1'b1;
                if (mem_we_o) dev_mem[mem_addr_o] = mem_wdata_o;
                else mem_rdata_i = dev_read(mem_addr_o);
            end
        end
    end

    // Monitor: checks request stability while waiting, pops the scoreboard
    // on every completed read, write and error, and counts done pulses.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (mem_req_o && prev_req && !prev_ack)
                checkOutput("req_stable", {31'd0, prev_req_bus != {mem_we_o, mem_addr_o, mem_wdata_o}}, 32'd0);
            if (mem_req_o && mem_ack_i) begin
                if (mem_we_o) begin
                    write_count++;
                    checkOutput("write_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        checkOutput("write_not_err", {31'd0, e.is_err}, 32'd0);
                        checkOutput("wr_addr", mem_addr_o, e.addr);
                        checkOutput("wr_data", mem_wdata_o, e.data);
                    end
                end else begin
                    checkOutput("read_expected", {31'd0, rd_q.size() > 0}, 32'd1);
                    if (rd_q.size() > 0) checkOutput("rd_addr", mem_addr_o, rd_q.pop_front());
                end
            end
            if (st_err_o) begin
                err_count++;
                last_event_cyc = cyc;
                checkOutput("err_no_req", {31'd0, mem_req_o}, 32'd0);
                checkOutput("err_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("err_kind", {31'd0, e.is_err}, 32'd1);
                end
            end
            if (st_done_o) begin
                done_count++;
                last_event_cyc = cyc;
            end
            prev_req     = mem_req_o;
            prev_ack     = mem_ack_i;
            prev_req_bus = {mem_we_o, mem_addr_o, mem_wdata_o};
        end
    end

    // Issue one store, wait (bounded) for it to finish and return the cycle
    // of its done/err pulse relative to the request cycle.
    task automatic applyStimulus(input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] data, output int latency);
        int start, d0, e0, n;
        bit legal;
        @(posedge clk); #1;
        checkOutput("idle_before_req", {31'd0, st_busy_o}, 32'd0);
        start = cyc;
        d0 = done_count;
        e0 = err_count;
        legal = model_push(size, addr, data);
        st_req_i  = 1'b1;
        st_size_i = size;
        st_addr_i = addr;
        st_data_i = data;
        @(posedge clk); #1;
        st_req_i = 1'b0;
        n = 0;
        while (st_busy_o && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("completion_timeout", {31'd0, st_busy_o}, 32'd0);
        checkOutput("done_pulses", done_count - d0, legal ? 32'd1 : 32'd0);
        checkOutput("err_pulses", err_count - e0, legal ? 32'd0 : 32'd1);
        latency = last_event_cyc - start;
    endtask

    initial begin
        int lat, start, d0, w0, n;
        bit ok;
        logic [1:0]  rsize;
        logic [31:0] raddr;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'd0, st_busy_o}, 32'd0);
        checkOutput("reset_done_err", {30'd0, st_done_o, st_err_o}, 32'd0);
        checkOutput("reset_mem_req_we", {30'd0, mem_req_o, mem_we_o}, 32'd0);
        checkOutput("reset_mem_addr", mem_addr_o, 32'd0);
        checkOutput("reset_mem_wdata", mem_wdata_o, 32'd0);
        rst = 1'b0;

        // Byte merge, zero-wait memory.
        zero_wait = 1'b1;
        preload(32'h1000, 32'h1122_3344);
        applyStimulus(MEM_ACCESS_SIZE_BYTE, 32'h1002, 32'h0000_00AB, lat);
        checkOutput("byte_latency", lat, 32'd3);
        checkOutput("byte_mem_word", dev_read(32'h1000), 32'h11AB_3344);

        // Half merge with 3 read waits and 2 write waits.
        preload(32'h2000, 32'hCAFE_0000);
        wait_q.push_back(3);
        wait_q.push_back(2);
        applyStimulus(MEM_ACCESS_SIZE_HALF, 32'h2002, 32'h0000_BEEF, lat);
        checkOutput("half_latency", lat, 32'd8);
        checkOutput("half_mem_word", dev_read(32'h2000), 32'hBEEF_0000);

        // Word store goes straight to the write.
        applyStimulus(MEM_ACCESS_SIZE_WORD, 32'h3000, 32'hDEAD_BEEF, lat);
        checkOutput("word_latency", lat, 32'd2);

        // Rejected stores.
        applyStimulus(MEM_ACCESS_SIZE_WORD, 32'h3001, 32'h1234_5678, lat);
        checkOutput("err_word_latency", lat, 32'd1);
        applyStimulus(MEM_ACCESS_SIZE_HALF, 32'h3003, 32'h0000_1234, lat);
        checkOutput("err_half_latency", lat, 32'd1);
        applyStimulus(2'd3, 32'h3004, 32'h0000_0055, lat);
        checkOutput("err_size_latency", lat, 32'd1);

        // Request held high through a byte store: re-accepted only after DONE.
        @(posedge clk); #1;
        start = cyc;
        d0 = done_count;
        ok = model_push(MEM_ACCESS_SIZE_BYTE, 32'h1001, 32'h0000_005A);
        ok = model_push(MEM_ACCESS_SIZE_BYTE, 32'h1001, 32'h0000_005A);
        st_req_i  = 1'b1;
        st_size_i = MEM_ACCESS_SIZE_BYTE;
        st_addr_i = 32'h1001;
        st_data_i = 32'h0000_005A;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("held_idle_after_done", {31'd0, st_busy_o}, 32'd0);
        @(posedge clk); #1;
        checkOutput("held_second_accept", {31'd0, st_busy_o}, 32'd1);
        st_req_i = 1'b0;
        n = 0;
        while (st_busy_o && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("held_timeout", {31'd0, st_busy_o}, 32'd0);
        checkOutput("held_done_count", done_count - d0, 32'd2);
        checkOutput("held_second_done_cyc", last_event_cyc - start, 32'd7);

        // Spurious ack while idle changes nothing.
        w0 = write_count;
        spurious_ack = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("spurious_idle", {31'd0, st_busy_o}, 32'd0);
        end
        spurious_ack = 1'b0;
        checkOutput("spurious_no_write", write_count - w0, 32'd0);

        // Asynchronous reset while the write waits for ack.
        ack_hold = 1'b1;
        @(posedge clk); #1;
        ok = model_push(MEM_ACCESS_SIZE_WORD, 32'hF000, 32'h1357_9BDF);
        st_req_i  = 1'b1;
        st_size_i = MEM_ACCESS_SIZE_WORD;
        st_addr_i = 32'hF000;
        st_data_i = 32'h1357_9BDF;
        @(posedge clk); #1;
        st_req_i = 1'b0;
        checkOutput("abort_in_wr", {30'd0, mem_req_o, mem_we_o}, 32'd3);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkOutput("abort_mem_req", {31'd0, mem_req_o}, 32'd0);
        checkOutput("abort_busy", {31'd0, st_busy_o}, 32'd0);
        exp_q.delete();
        rd_q.delete();
        ack_hold = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(MEM_ACCESS_SIZE_WORD, 32'hF000, 32'h2468_ACE0, lat);
        checkOutput("post_reset_word_latency", lat, 32'd2);

        // Randomized stores over a small window with random wait states.
        zero_wait = 1'b0;
        for (int i = 0; i < 60; i++) begin
            n = int'($urandom_range(0, 9));
            rsize = (n == 0) ? 2'd3 : 2'(n % 3);
            raddr = 32'h0 + $urandom_range(0, 63);
            applyStimulus(rsize, raddr, $urandom, lat);
            if (rsize == 2'd3 || (rsize == 2'd1 && raddr[0]) || (rsize == 2'd2 && raddr[1:0] != 2'b00))
                checkOutput("rand_err_latency", lat, 32'd1);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
        checkOutput("reads_drained", rd_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
